// File: rtl/req_ack_xfr_arbiter.sv
// Round-robin share of one transfer engine; ack/xfr_start one cycle after req is sampled in IDLE.
// No backpressure: late requests wait (held) until IDLE; the engine is held until done_xfr or timeout.
module req_ack_xfr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    localparam int IW     = $clog2(N_REQ),
    localparam int CW     = $clog2(TIMEOUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done_xfr,
    output logic [N_REQ-1:0] ack,
    output logic             xfr_start,
    output logic [IW-1:0]    xfr_id,
    output logic             busy,
    output logic             timeout_err,
    output logic             spurious_done
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             cnt_last;
    logic [N_REQ-1:0] ack_nxt;
    logic             start_nxt, busy_nxt, terr_nxt, spur_nxt;

    assign cnt_last = (cnt == CW'(TIMEOUT - 1));

    // Search upward from ptr+1 so the last winner has the lowest priority.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = GRANT;
            GRANT:   state_nxt = XFER;
            XFER:    if (done_xfr || cnt_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done_xfr takes precedence over an expiring timeout in the same cycle.
    always_comb begin
        ack_nxt   = '0;
        start_nxt = 1'b0;
        cnt_nxt   = cnt;
        busy_nxt  = (state_nxt != IDLE);
        terr_nxt  = timeout_err;
        spur_nxt  = spurious_done;
        case (state)
            GRANT: begin
                ack_nxt   = N_REQ'(1) << xfr_id;
                start_nxt = 1'b1;
                cnt_nxt   = '0;
            end
            XFER: begin
                cnt_nxt = cnt + 1'b1;
                if (!done_xfr && cnt_last) terr_nxt = 1'b1;
            end
            default: ;
        endcase
        if (done_xfr && state != XFER) spur_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= IW'(N_REQ - 1);
            cnt           <= '0;
            xfr_id        <= '0;
            ack           <= '0;
            xfr_start     <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            spurious_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            ack           <= ack_nxt;
            xfr_start     <= start_nxt;
            busy          <= busy_nxt;
            timeout_err   <= terr_nxt;
            spurious_done <= spur_nxt;
            if (state == IDLE && win_vld) begin
                xfr_id <= win_idx;
                ptr    <= win_idx;
            end
        end
    end
endmodule

// File: doc/req_ack_xfr_arbiter.md
# req_ack_xfr_arbiter

Round-robin arbiter and sequencer that shares one transfer engine among `N_REQ` requesters using the req/ack/done_xfr handshake. It grants one requester at a time and issues a single-cycle `ack` plus a start strobe to the engine. It then holds the engine until `done_xfr` or a timeout, and only after that considers the next request. The block sits between the requester agents and the transfer engine; the existing req/ack/done_xfr assertion checker binds to each requester's signal triple unchanged.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT`, default 16: maximum cycles in XFER waiting for `done_xfr`, ≥2.
- `clk` input, 1 bit: clock; all logic updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `req` input, `N_REQ` bits: per-requester request, level, held until its `ack`.
- `done_xfr` input, 1 bit: single-cycle pulse from the engine; the current transfer is complete.
- `ack` output, `N_REQ` bits: one-hot grant pulse, one cycle.
- `xfr_start` output, 1 bit: start strobe to the engine, coincident with `ack`.
- `xfr_id` output, `$clog2(N_REQ)` bits: index of the granted requester, stable from GRANT through XFER.
- `busy` output, 1 bit: high in GRANT and XFER.
- `timeout_err` output, 1 bit: sticky; set when a transfer times out.
- `spurious_done` output, 1 bit: sticky; set when `done_xfr` arrives outside XFER.

## Operation
- Reset values: `ack`=0, `xfr_start`=0, `xfr_id`=0, `busy`=0, `timeout_err`=0, `spurious_done`=0, state=IDLE, RR pointer=`N_REQ-1`, timeout counter=0.
- All outputs are registered.
- State machine: IDLE, GRANT, XFER.
- **IDLE**
  - If `req`≠0, select the winner: the first set bit searching upward from pointer+1, wrapping modulo `N_REQ`.
  - Load `xfr_id` and the pointer with the winner and go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT** (exactly one cycle)
  - `ack[xfr_id]`=1, `xfr_start`=1, `busy`=1.
  - Clear the timeout counter; go to XFER.
- **XFER**
  - `busy`=1.
  - Counter increments each cycle.
  - `done_xfr`=1 → IDLE.
  - Else, counter = `TIMEOUT-1` → set `timeout_err`, go to IDLE.
  - `done_xfr` and the timeout in the same cycle: `done_xfr` wins; `timeout_err` is not set.
- **Requester rule:** drop `req` the cycle after sampling `ack`. A `req` still high once back in IDLE is treated as a new request.
- **Fairness:** pointer = last granted index. Bit `pointer` has the lowest priority in the next arbitration.
- **Spurious done:** `done_xfr` in IDLE or GRANT sets `spurious_done` and has no other effect.
- **Late requests:** requests arriving in GRANT or XFER are not sampled until IDLE; they are not lost while held.
- **Reset mid-operation:** asynchronous return to the reset values. Any in-flight transfer is abandoned; the engine is reset from the same `rst_n`.

## Timing
- Request to grant:
  - `req[i]` rises before edge t while in IDLE → GRANT after edge t.
  - `ack[i]`/`xfr_start` are high from edge t+1 to edge t+2, i.e. `ack` is visible one cycle after `req` is sampled.
- Done to next grant:
  - `done_xfr` sampled at edge d → IDLE after d.
  - Next `ack` no earlier than edge d+2.
- Timeout: the engine is released at most `TIMEOUT`+1 cycles after the `ack` cycle.
- Back-to-back throughput: one transfer per (engine latency + 3) cycles.

## Test plan
- **Single request:** reset, `req`=4'b0010 → `ack`=4'b0010 for exactly one cycle, one cycle after `req`. `xfr_id`=1, `xfr_start`=1. `busy` holds until `done_xfr` 5 cycles later, then IDLE.
- **Round-robin:** `req`=4'b1111 held and re-asserted after each transfer, `done_xfr` 3 cycles after each `ack` → grant order 0,1,2,3,0. No `ack` overlaps another `ack`.
- **Timeout:** grant requester 2 and never assert `done_xfr` → `timeout_err`=1 after 16 XFER cycles and stays set. The next pending `req[3]` is granted 2 cycles later.
- **Done/timeout collision:** `done_xfr` on the cycle the counter reaches 15 → `timeout_err` stays 0 and the FSM returns to IDLE.
- **Spurious done:** `done_xfr` pulse in IDLE → `spurious_done`=1. No `ack`, state unchanged.
- **Reset mid-transfer:** drop `rst_n` during XFER → all outputs 0 immediately (asynchronously). After release with `req`=4'b1000, `ack`=4'b1000 is the first grant because the pointer reset to 3 and requester 3 is the only request.
